// File: rtl/sw_capture_ctrl_pkg.sv
// Shared definitions for the lab2 switch-capture controller: state encoding and
// default sizing reused by the counter and hex-decoder users.
package sw_capture_ctrl_pkg;

  typedef enum logic {
    StLive = 1'b0,
    StView = 1'b1
  } state_e;

  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefViewTo = 100_000_000;
  localparam int unsigned SimViewTo = 16;

endpackage

// File: rtl/sw_capture_ctrl_view_timer.sv
// Loadable down-counter that times out the history browse; held at zero
// whenever it is neither loaded nor counting.
module sw_capture_ctrl_view_timer #(
  parameter int unsigned VIEW_TO = 16
) (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned TW = (VIEW_TO > 1) ? $clog2(VIEW_TO) : 1;

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= TW'(VIEW_TO - 1);
    end else if (en_i) begin
      if (cnt_q != '0) cnt_q <= cnt_q - TW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sw_capture_ctrl.sv
// Switch-capture controller: records sw_i into a circular history on each
// capture pulse, counts captures and sequences a timed browse of the history.
module sw_capture_ctrl
  import sw_capture_ctrl_pkg::*;
#(
  parameter int unsigned SW_W    = 10,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned VIEW_TO = DefViewTo
) (
  input  logic                     clk100_i,
  input  logic                     rstn_i,
  input  logic                     cap_evt_i,
  input  logic                     view_evt_i,
  input  logic                     clr_i,
  input  logic [SW_W-1:0]          sw_i,
  output logic [SW_W-1:0]          ledr_o,
  output logic [CNT_W-1:0]         cnt_o,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     view_o,
  output logic                     full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned FW = PW + 1;

  state_e          state_q;
  logic [SW_W-1:0] hist_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [FW-1:0]   fill_q;
  logic [SW_W-1:0] ledr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]   idx_q;
  logic            full_q;

  logic [PW-1:0] newest_ptr, step_ptr;
  logic [FW-1:0] idx_next;
  logic          do_cap, do_view, view_enter, view_step, view_exit;
  logic          tmr_en, tmr_load, tmr_expired, tmr_exp;

  assign newest_ptr = wr_ptr_q - PW'(1);
  // Entry one step older than the one on display: wr_ptr-1-(idx+1).
  assign step_ptr   = wr_ptr_q - idx_q - PW'(2);
  assign idx_next   = {1'b0, idx_q} + FW'(1);

  // Priority: clr > capture > view > timer expiry.
  always_comb begin
    do_cap     = !clr_i && cap_evt_i;
    do_view    = !clr_i && !cap_evt_i && view_evt_i;
    view_enter = do_view && (state_q == StLive) && (fill_q != '0);
    view_step  = do_view && (state_q == StView) && (idx_next < fill_q);
    view_exit  = do_view && (state_q == StView) && !(idx_next < fill_q);
    tmr_en     = !clr_i && !cap_evt_i && !view_evt_i && (state_q == StView);
    tmr_exp    = tmr_en && tmr_expired;
    tmr_load   = view_enter || view_step;
  end

  sw_capture_ctrl_view_timer #(
    .VIEW_TO (VIEW_TO)
  ) u_view_timer (
    .clk100_i  (clk100_i),
    .rstn_i    (rstn_i),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StLive;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      ledr_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      full_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else if (clr_i) begin
      state_q  <= StLive;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      ledr_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      full_q   <= 1'b0;
    end else if (do_cap) begin
      hist_q[wr_ptr_q] <= sw_i;
      wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fill_q != FW'(DEPTH)) fill_q <= fill_q + FW'(1);
      full_q   <= (fill_q >= FW'(DEPTH - 1));
      cnt_q    <= cnt_q + CNT_W'(1);
      ledr_q   <= sw_i;
      idx_q    <= '0;
      state_q  <= StLive;
    end else if (view_enter) begin
      state_q <= StView;
      idx_q   <= '0;
      ledr_q  <= hist_q[newest_ptr];
    end else if (view_step) begin
      idx_q  <= idx_q + PW'(1);
      ledr_q <= hist_q[step_ptr];
    end else if (view_exit || tmr_exp) begin
      state_q <= StLive;
      idx_q   <= '0;
      ledr_q  <= hist_q[newest_ptr];
    end
  end

  assign ledr_o = ledr_q;
  assign cnt_o  = cnt_q;
  assign idx_o  = idx_q;
  assign view_o = (state_q == StView);
  assign full_o = full_q;

endmodule

// File: tb/tb_sw_capture_ctrl.sv
// Scoreboard bench for sw_capture_ctrl: stimulus queues hand-computed outputs
// tagged with the cycle they must appear in; a monitor pops and compares.
module tb_sw_capture_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cap = 1'b0, view = 1'b0, clr = 1'b0;
  logic [9:0] sw = '0;
  logic [9:0] ledr;
  logic [7:0] cnt;
  logic [1:0] idx;
  logic       view_o, full_o;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    string      name;
    int         cyc;
    logic [9:0] ledr;
    logic [7:0] cnt;
    logic [1:0] idx;
    logic       view;
    logic       full;
  } exp_t;

  exp_t q[$];
  exp_t e;

  sw_capture_ctrl #(
    .SW_W    (10),
    .CNT_W   (8),
    .DEPTH   (4),
    .VIEW_TO (16)
  ) dut (
    .clk100_i   (clk),
    .rstn_i     (rstn),
    .cap_evt_i  (cap),
    .view_evt_i (view),
    .clr_i      (clr),
    .sw_i       (sw),
    .ledr_o     (ledr),
    .cnt_o      (cnt),
    .idx_o      (idx),
    .view_o     (view_o),
    .full_o     (full_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [21:0] got, logic [21:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got ledr=%h cnt=%h idx=%0d view=%b full=%b, want ledr=%h cnt=%h idx=%0d view=%b full=%b",
                  name, got[21:12], got[11:4], got[3:2], got[1], got[0],
                  want[21:12], want[11:4], want[3:2], want[1], want[0]);
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc != cyc) begin
        n_checks++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else begin
        check(e.name, {ledr, cnt, idx, view_o, full_o}, {e.ledr, e.cnt, e.idx, e.view, e.full});
      end
    end
  end

  task automatic step(input logic c, input logic v, input logic cl, input logic [9:0] s);
    cap = c; view = v; clr = cl; sw = s;
    @(posedge clk); #1;
    cap = 1'b0; view = 1'b0; clr = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic [9:0] l, input logic [7:0] c,
                            input logic [1:0] i, input logic v, input logic f);
    q.push_back('{n, cyc, l, c, i, v, f});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    step(0, 0, 0, 10'h000); expect_out("reset", 10'h000, 8'd0, 2'd0, 0, 0);

    step(1, 0, 0, 10'h001); expect_out("cap1", 10'h001, 8'd1, 2'd0, 0, 0);
    step(1, 0, 0, 10'h002); expect_out("cap2", 10'h002, 8'd2, 2'd0, 0, 0);
    step(1, 0, 0, 10'h003); expect_out("cap3", 10'h003, 8'd3, 2'd0, 0, 0);
    step(0, 1, 0, 10'h000); expect_out("view_pre_rst", 10'h003, 8'd3, 2'd0, 1, 0);

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    @(posedge clk); #3 rstn = 1'b0;
    #1 check("async_rst", {ledr, cnt, idx, view_o, full_o}, 22'd0);
    @(posedge clk); #1 rstn = 1'b1;

    step(0, 1, 0, 10'h000); expect_out("view_empty", 10'h000, 8'd0, 2'd0, 0, 0);

    step(1, 0, 0, 10'h011); expect_out("h011", 10'h011, 8'd1, 2'd0, 0, 0);
    step(1, 0, 0, 10'h012); expect_out("h012", 10'h012, 8'd2, 2'd0, 0, 0);
    step(1, 0, 0, 10'h013); expect_out("h013", 10'h013, 8'd3, 2'd0, 0, 0);
    step(1, 0, 0, 10'h014); expect_out("h014", 10'h014, 8'd4, 2'd0, 0, 1);
    step(1, 0, 0, 10'h015); expect_out("h015", 10'h015, 8'd5, 2'd0, 0, 1);
    step(0, 1, 0, 10'h000); expect_out("browse0", 10'h015, 8'd5, 2'd0, 1, 1);
    step(0, 1, 0, 10'h000); expect_out("browse1", 10'h014, 8'd5, 2'd1, 1, 1);
    step(0, 1, 0, 10'h000); expect_out("browse2", 10'h013, 8'd5, 2'd2, 1, 1);
    step(0, 1, 0, 10'h000); expect_out("browse3", 10'h012, 8'd5, 2'd3, 1, 1);
    step(0, 1, 0, 10'h000); expect_out("browse_end", 10'h015, 8'd5, 2'd0, 0, 1);

    step(0, 0, 1, 10'h000); expect_out("clr1", 10'h000, 8'd0, 2'd0, 0, 0);
    step(0, 1, 0, 10'h000); expect_out("view_after_clr", 10'h000, 8'd0, 2'd0, 0, 0);
    step(1, 0, 0, 10'h2AA); expect_out("cap_2aa", 10'h2AA, 8'd1, 2'd0, 0, 0);
    step(0, 1, 0, 10'h000); expect_out("timeout_enter", 10'h2AA, 8'd1, 2'd0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 0, 10'h000); expect_out("timeout_hold", 10'h2AA, 8'd1, 2'd0, 1, 0);
    end
    step(0, 0, 0, 10'h000); expect_out("timeout_exit", 10'h2AA, 8'd1, 2'd0, 0, 0);

    step(0, 1, 0, 10'h000); expect_out("view_again", 10'h2AA, 8'd1, 2'd0, 1, 0);
    step(1, 1, 0, 10'h3FF); expect_out("cap_and_view", 10'h3FF, 8'd2, 2'd0, 0, 0);

    step(1, 0, 1, 10'h155); expect_out("clr_beats_cap", 10'h000, 8'd0, 2'd0, 0, 0);

    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 10'(i));
      expect_out("wrap", 10'(i), 8'((i + 1) % 256), 2'd0, 0, (i >= 3));
    end
    step(0, 1, 0, 10'h000); expect_out("view_after_wrap", 10'h0FF, 8'd0, 2'd0, 1, 1);
    step(0, 0, 1, 10'h000); expect_out("clr_in_view", 10'h000, 8'd0, 2'd0, 0, 0);
    step(0, 1, 0, 10'h000); expect_out("view_ignored", 10'h000, 8'd0, 2'd0, 0, 0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sw_capture_ctrl.md
Name: sw_capture_ctrl

Overview:
- Controller for the lab2 switch-capture/press-counter datapath.
- Takes one-cycle press pulses from the button_check instances and captures sw_i into a DEPTH-entry history buffer.
- Counts captures and sequences what ledr_o shows: live capture, or a timed browse through the history.
- Outputs feed ledr_o directly; cnt_o feeds the two dec_hex instances.

Parameters:
SW_W, 10, width of switch word and LED bus
CNT_W, 8, press-counter width (two hex digits)
DEPTH, 4, history entries (power of two, >=2)
VIEW_TO, 100_000_000, VIEW idle timeout in clk100_i cycles (1 s); benches override to 16

Ports:
clk100_i  in  1  100 MHz system clock
rstn_i  in  1  asynchronous active-low reset
cap_evt_i  in  1  one-cycle capture pulse (debounced key0 press)
view_evt_i  in  1  one-cycle browse pulse (debounced key1 press)
clr_i  in  1  synchronous clear, level
sw_i  in  SW_W  switch word
ledr_o  out  SW_W  displayed word
cnt_o  out  CNT_W  capture count to hex decoders
idx_o  out  log2(DEPTH)  age of displayed entry, 0 = newest
view_o  out  1  high in VIEW state
full_o  out  1  history holds DEPTH entries

Behaviour:
- Reset: state LIVE, wr_ptr=0, fill=0, timer=0, buffer contents 0; all outputs 0.
- All outputs registered. Any event is reflected on the outputs on the clock edge after the event cycle.
- States: LIVE, VIEW.
- Priority per cycle: clr_i > cap_evt_i > view_evt_i > timer expiry.
- clr_i:
  - fill=0, wr_ptr=0, cnt_o=0, ledr_o=0, idx_o=0, state LIVE.
  - Buffer contents need not be cleared.
- cap_evt_i, either state:
  - buf[wr_ptr] <= sw_i; wr_ptr <= wr_ptr+1 mod DEPTH.
  - fill <= min(fill+1, DEPTH); when full, the oldest entry is overwritten.
  - cnt_o <= cnt_o+1, wrapping from 2^CNT_W-1 to 0.
  - ledr_o <= sw_i; idx_o <= 0; state LIVE. A capture aborts VIEW.
- view_evt_i in LIVE:
  - fill==0: ignored.
  - Otherwise enter VIEW at idx=0, showing buf[wr_ptr-1]; timer <= VIEW_TO-1.
- view_evt_i in VIEW:
  - If idx+1 < fill: idx <= idx+1; ledr_o <= buf[wr_ptr-1-idx-1]; timer reloaded.
  - Otherwise return to LIVE with ledr_o = newest entry and idx_o=0.
- Timer in VIEW:
  - Decrements every cycle without an event.
  - At 0 the state returns to LIVE on that edge; ledr_o = newest entry, idx_o=0.
  - Timer is held at 0 in LIVE.
- cap_evt_i and view_evt_i in the same cycle: capture is performed and the view event is dropped.
- Pointer arithmetic is modulo DEPTH. fill is log2(DEPTH)+1 bits wide.
- full_o = (fill==DEPTH).
- Asserting rstn_i mid-VIEW or mid-capture returns everything to the reset values immediately, without waiting for a clock.
- sw_i is sampled only in cycles where cap_evt_i is high.

Decomposition:
- Shared include lab_pkg.vh:
  - state encodings ST_LIVE=1'b0, ST_VIEW=1'b1.
  - default VIEW_TO and SIM_VIEW_TO=16.
  - CNT_W default, reused by counter and dec_hex users.
- One sub-module: view_timer.
  - Loadable down-counter with load, enable and expired outputs; width clog2(VIEW_TO).
- Buffer and FSM stay in sw_capture_ctrl.

Test Plan:
- Reset with rstn_i=0 mid-operation -> ledr_o=0, cnt_o=0, view_o=0, full_o=0 asynchronously.
- Captures with sw_i=10'h001, 002, 003 -> after each, ledr_o equals that value one cycle later; cnt_o=1,2,3; full_o=0.
- Five captures 0x011..0x015 then view_evt_i x4 (VIEW_TO=16) -> ledr_o/idx_o = 0x015/0, 0x014/1, 0x013/2, 0x012/3; the 5th view_evt_i returns to LIVE with ledr_o=0x015. Entry 0x011 never appears; full_o=1.
- view_evt_i with fill=0 -> view_o stays 0. Then one capture 0x2AA, one view_evt_i, no further events -> view_o=1 for exactly 16 cycles, then view_o=0 and ledr_o=0x2AA.
- Simultaneous cap_evt_i and view_evt_i with sw_i=0x3FF in VIEW -> view_o=0, ledr_o=0x3FF, cnt_o incremented.
- Counter wrap and clear: 256 captures -> cnt_o=0x00. Then clr_i during VIEW -> cnt_o=0, fill=0, and a following view_evt_i is ignored.
